// File: rtl/hex_digit_counter.sv
`default_nettype none
// ============================================================================
//  Module   : hex_digit_counter
//  Purpose  : Single hex digit source for the 7-segment decoder stage. A rate
//             divider issues enable ticks at a speed-selectable period, and a
//             4-bit up/down counter with parallel load advances on each tick.
//             tick/wrap are provided so further digits can be cascaded.
//  Options  : define HEX_COUNTER_BCD_EN to restrict the count to 0..9
//             (decimal digit, load values above 9 saturate to 9).
//  Revision : 1.0 - initial release
// ============================================================================
module hex_digit_counter #(
  parameter int CLK_HZ = 50000000,
  parameter int DIV_W  = 28
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       up_down,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic [3:0] digit,
  output logic       tick,
  output logic       wrap
);

  // Periods are formed in 64 bits first so 4*CLK_HZ cannot overflow before
  // being narrowed to the divider width.
  localparam logic [63:0]      c_hz64      = 64'(CLK_HZ);
  localparam logic [DIV_W-1:0] c_reload_00 = '0;
  localparam logic [DIV_W-1:0] c_reload_01 = DIV_W'(c_hz64 - 64'd1);
  localparam logic [DIV_W-1:0] c_reload_10 = DIV_W'((c_hz64 * 64'd2) - 64'd1);
  localparam logic [DIV_W-1:0] c_reload_11 = DIV_W'((c_hz64 * 64'd4) - 64'd1);

`ifdef HEX_COUNTER_BCD_EN
  localparam logic [3:0] c_digit_max = 4'd9;
`else
  localparam logic [3:0] c_digit_max = 4'hF;
`endif

  logic [1:0]       r_speed_q;
  logic [DIV_W-1:0] r_divider;
  logic [3:0]       r_digit;

  logic [DIV_W-1:0] w_reload;
  logic             w_speed_change;
  logic             w_div_zero;
  logic             w_tick;
  logic             w_wrap;
  logic             w_at_max;
  logic             w_at_min;
  logic [3:0]       w_step_digit;
  logic [3:0]       w_load_digit;

  // Divider reload value (period minus one) for the currently selected speed.
  always_comb begin
    w_reload = c_reload_00;
    case (speed)
      2'b00:   w_reload = c_reload_00;
      2'b01:   w_reload = c_reload_01;
      2'b10:   w_reload = c_reload_10;
      2'b11:   w_reload = c_reload_11;
      default: w_reload = c_reload_00;
    endcase
  end

  assign w_speed_change = (speed != r_speed_q);
  assign w_div_zero     = (r_divider == '0);

  // tick is gated by reset so it stays low for the whole reset interval even
  // though the divider sits at zero during reset.
  assign w_tick = ~reset & enable & ~load & ~w_speed_change & w_div_zero;

  assign w_at_max = (r_digit >= c_digit_max);
  assign w_at_min = (r_digit == 4'd0);
  assign w_wrap   = w_tick & (up_down ? w_at_max : w_at_min);

  // Next counter value on a tick, rolling over at either end of the range.
  always_comb begin
    w_step_digit = r_digit;
    if (up_down) begin
      w_step_digit = w_at_max ? 4'd0 : (r_digit + 4'd1);
    end else begin
      w_step_digit = w_at_min ? c_digit_max : (r_digit - 4'd1);
    end
  end

  // Parallel load value; in decimal mode anything above 9 is clamped.
  always_comb begin
    w_load_digit = load_value;
`ifdef HEX_COUNTER_BCD_EN
    if (load_value > 4'd9) begin
      w_load_digit = 4'd9;
    end
`endif
  end

  // Track the previous speed selection to detect a change of rate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_speed_q <= 2'b00;
    end else begin
      r_speed_q <= speed;
    end
  end

  // Rate divider: reload on load/speed change/tick, count down while enabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_divider <= '0;
    end else if (load || w_speed_change || w_tick) begin
      r_divider <= w_reload;
    end else if (enable) begin
      r_divider <= r_divider - DIV_W'(1);
    end
  end

  // Digit counter: load has priority, a speed change freezes it for a cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_digit <= 4'd0;
    end else if (load) begin
      r_digit <= w_load_digit;
    end else if (w_speed_change) begin
      r_digit <= r_digit;
    end else if (w_tick) begin
      r_digit <= w_step_digit;
    end
  end

  assign digit = r_digit;
  assign tick  = w_tick;
  assign wrap  = w_wrap;

endmodule
`default_nettype wire

// File: tb/tb_hex_digit_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_digit_counter
//  Purpose  : Self-checking bench for hex_digit_counter with a small clock
//             rate (CLK_HZ=4) so the slow speeds are reachable quickly.
//             Reference model counts enabled cycles since the last period
//             start and ticks on the P-th one.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hex_digit_counter;

  localparam int CLK_HZ = 4;
  localparam int DIV_W  = 8;

`ifdef HEX_COUNTER_BCD_EN
  localparam int c_max = 9;
  localparam int c_load_a = 9;
`else
  localparam int c_max = 15;
  localparam int c_load_a = 10;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] speed = 2'b00;
  logic       up_down = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic [3:0] digit;
  logic       tick;
  logic       wrap;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         m_digit = 0;
  int         m_elapsed = 0;
  logic [1:0] m_speed_q = 2'b00;

  hex_digit_counter #(
    .CLK_HZ(CLK_HZ),
    .DIV_W (DIV_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .speed     (speed),
    .up_down   (up_down),
    .load      (load),
    .load_value(load_value),
    .digit     (digit),
    .tick      (tick),
    .wrap      (wrap)
  );

  always #5 clock = ~clock;

  function automatic int m_period(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return CLK_HZ;
      2'b10:   return 2 * CLK_HZ;
      default: return 4 * CLK_HZ;
    endcase
  endfunction

  function automatic logic m_tick();
    return !reset && enable && !load && (speed == m_speed_q) &&
           (m_elapsed == m_period(speed) - 1);
  endfunction

  function automatic logic m_wrap();
    return m_tick() && (up_down ? (m_digit == c_max) : (m_digit == 0));
  endfunction

  function automatic int m_load_val(input logic [3:0] v);
    return (int'(v) > c_max) ? c_max : int'(v);
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic m_update();
    logic t;
    t = m_tick();
    if (reset) begin
      m_digit   = 0;
      m_elapsed = 0;
      m_speed_q = 2'b00;
    end else begin
      if (load) begin
        m_digit   = m_load_val(load_value);
        m_elapsed = 0;
      end else if (speed != m_speed_q) begin
        m_elapsed = 0;
      end else if (t) begin
        m_digit   = up_down ? (m_digit + 1) % (c_max + 1)
                            : (m_digit + c_max) % (c_max + 1);
        m_elapsed = 0;
      end else if (enable) begin
        m_elapsed++;
      end
      m_speed_q = speed;
    end
  endtask

  task automatic adv();
    m_update();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; speed = 2'b00; load = 1'b0;
    up_down = 1'b1; load_value = 4'd0;
    adv();
    adv();
    #2;
    n_checks++;
    if (digit !== 4'd0) begin n_errors++; $display("FAIL reset_digit: got %0d expected 0", digit); end
    n_checks++;
    if (tick !== 1'b0) begin n_errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
    n_checks++;
    if (wrap !== 1'b0) begin n_errors++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
    adv();
    reset = 1'b0;
  endtask

  task automatic test_count_up();
    test_reset();
    speed = 2'b00; enable = 1'b1; up_down = 1'b1;
    for (int k = 0; k < 18; k++) begin
      #2;
      n_checks++;
      if (digit !== 4'(k % (c_max + 1))) begin
        n_errors++; $display("FAIL up_digit[%0d]: got %0d expected %0d", k, digit, k % (c_max + 1));
      end
      n_checks++;
      if (tick !== 1'b1) begin n_errors++; $display("FAIL up_tick[%0d]: got %b expected 1", k, tick); end
      n_checks++;
      if (wrap !== ((k % (c_max + 1)) == c_max)) begin
        n_errors++; $display("FAIL up_wrap[%0d]: got %b expected %b", k, wrap, (k % (c_max + 1)) == c_max);
      end
      adv();
    end
  endtask

  task automatic test_speed_01();
    test_reset();
    speed = 2'b01; enable = 1'b1; up_down = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #2;
      n_checks++;
      if (tick !== (k >= 4 && (k % 4) == 0)) begin
        n_errors++; $display("FAIL s01_tick[%0d]: got %b expected %b", k, tick, (k >= 4 && (k % 4) == 0));
      end
      adv();
      if (k == 8) begin
        n_checks++;
        if (digit !== 4'd2) begin n_errors++; $display("FAIL s01_digit: got %0d expected 2", digit); end
      end
    end
  endtask

  task automatic test_enable_pause();
    test_reset();
    speed = 2'b11; up_down = 1'b1;
    for (int k = 0; k < 26; k++) begin
      enable = !(k >= 6 && k <= 10);
      #2;
      n_checks++;
      if (tick !== (k == 21)) begin
        n_errors++; $display("FAIL pause_tick[%0d]: got %b expected %b", k, tick, k == 21);
      end
      adv();
    end
    enable = 1'b1;
    n_checks++;
    if (digit !== 4'd1) begin n_errors++; $display("FAIL pause_digit: got %0d expected 1", digit); end
  endtask

  task automatic test_load_tick();
    test_reset();
    speed = 2'b01; enable = 1'b1; up_down = 1'b1; load_value = 4'hA;
    for (int k = 0; k < 10; k++) begin
      load = (k == 4);
      #2;
      n_checks++;
      if (tick !== (k == 8)) begin
        n_errors++; $display("FAIL load_tick[%0d]: got %b expected %b", k, tick, k == 8);
      end
      n_checks++;
      if (wrap !== 1'b0) begin n_errors++; $display("FAIL load_wrap[%0d]: got %b expected 0", k, wrap); end
      adv();
      if (k == 4) begin
        n_checks++;
        if (digit !== 4'(c_load_a)) begin
          n_errors++; $display("FAIL load_digit: got %0d expected %0d", digit, c_load_a);
        end
      end
      if (k == 8) begin
        n_checks++;
        if (digit !== 4'((c_load_a + 1) % (c_max + 1))) begin
          n_errors++; $display("FAIL load_next: got %0d expected %0d", digit, (c_load_a + 1) % (c_max + 1));
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_count_down();
    test_reset();
    speed = 2'b00; enable = 1'b1; up_down = 1'b0;
    #2;
    n_checks++;
    if (wrap !== 1'b1) begin n_errors++; $display("FAIL down_wrap0: got %b expected 1", wrap); end
    adv();
    #2;
    n_checks++;
    if (digit !== 4'(c_max)) begin n_errors++; $display("FAIL down_digit1: got %0d expected %0d", digit, c_max); end
    n_checks++;
    if (wrap !== 1'b0) begin n_errors++; $display("FAIL down_wrap1: got %b expected 0", wrap); end
    adv();
    n_checks++;
    if (digit !== 4'(c_max - 1)) begin n_errors++; $display("FAIL down_digit2: got %0d expected %0d", digit, c_max - 1); end
    up_down = 1'b1;
  endtask

  task automatic test_mid_reset();
    test_reset();
    speed = 2'b00; enable = 1'b1; up_down = 1'b1;
    repeat (5) adv();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (digit !== 4'd0) begin n_errors++; $display("FAIL midrst_digit: got %0d expected 0", digit); end
    n_checks++;
    if (tick !== 1'b0) begin n_errors++; $display("FAIL midrst_tick: got %b expected 0", tick); end
    adv();
    reset = 1'b0;
    #2;
    n_checks++;
    if (tick !== 1'b1) begin n_errors++; $display("FAIL midrst_first_tick: got %b expected 1", tick); end
    adv();
    n_checks++;
    if (digit !== 4'd1) begin n_errors++; $display("FAIL midrst_after: got %0d expected 1", digit); end
  endtask

`ifdef HEX_COUNTER_BCD_EN
  task automatic test_bcd();
    test_reset();
    speed = 2'b00; enable = 1'b1; up_down = 1'b1;
    load = 1'b1; load_value = 4'd8;
    adv();
    load = 1'b0;
    #2;
    n_checks++;
    if (digit !== 4'd8 || wrap !== 1'b0) begin
      n_errors++; $display("FAIL bcd_8: got digit %0d wrap %b expected 8/0", digit, wrap);
    end
    adv();
    #2;
    n_checks++;
    if (digit !== 4'd9 || wrap !== 1'b1) begin
      n_errors++; $display("FAIL bcd_9: got digit %0d wrap %b expected 9/1", digit, wrap);
    end
    adv();
    n_checks++;
    if (digit !== 4'd0) begin n_errors++; $display("FAIL bcd_0: got %0d expected 0", digit); end
    load = 1'b1; load_value = 4'hC;
    adv();
    load = 1'b0;
    n_checks++;
    if (digit !== 4'd9) begin n_errors++; $display("FAIL bcd_sat: got %0d expected 9", digit); end
  endtask
`endif

  task automatic test_random();
    int n_ticks;
    n_ticks = 0;
    test_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) speed = 2'($urandom_range(0, 3));
      enable     = ($urandom_range(0, 99) < 85);
      load       = ($urandom_range(0, 99) < 4);
      load_value = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 10) up_down = ~up_down;
      reset      = ($urandom_range(0, 299) == 0);
      #2;
      if (m_tick()) n_ticks++;
      n_checks++;
      if (tick !== m_tick()) begin
        n_errors++; $display("FAIL rand_tick[%0d]: got %b expected %b", i, tick, m_tick());
      end
      n_checks++;
      if (wrap !== m_wrap()) begin
        n_errors++; $display("FAIL rand_wrap[%0d]: got %b expected %b", i, wrap, m_wrap());
      end
      n_checks++;
      if (digit !== 4'(reset ? 0 : m_digit)) begin
        n_errors++; $display("FAIL rand_digit[%0d]: got %0d expected %0d", i, digit, reset ? 0 : m_digit);
      end
      adv();
    end
    reset = 1'b0; load = 1'b0;
    n_checks++;
    if (n_ticks < 50) begin
      n_errors++; $display("FAIL rand_activity: got %0d ticks expected at least 50", n_ticks);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_speed_01();
    test_enable_pause();
    test_load_tick();
    test_count_down();
    test_mid_reset();
`ifdef HEX_COUNTER_BCD_EN
    test_bcd();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
